// File: rtl/root_sum_unit_pkg.sv
// root_sum_unit_pkg
//   Shared definitions for the root_sum_unit function unit.
//   - Mode encoding: MODE_CBRT (integer cube root) and MODE_SQRT (integer square root).
//   - FSM state enum for the top level.
//   - Helpers that give the iteration count and the initial trial shift for a given
//     operand width and mode.
package root_sum_unit_pkg;

    localparam logic MODE_CBRT = 1'b0;
    localparam logic MODE_SQRT = 1'b1;

    // Wide enough for any initial shift with W up to 32 (largest shift is W-1).
    localparam int SHIFT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        ROOT,
        SUM
    } state_t;

    // ceil(w/3) iterations for cube root, ceil(w/2) for square root.
    function automatic int iter_count(input int w, input logic mode);
        if (mode == MODE_SQRT) begin
            return (w + 1) / 2;
        end
        return (w + 2) / 3;
    endfunction

    // Bits consumed per iteration.
    function automatic int shift_step(input logic mode);
        return (mode == MODE_SQRT) ? 2 : 3;
    endfunction

    // Shift of the first trial; the last iteration always runs with shift 0.
    function automatic int init_shift(input int w, input logic mode);
        return shift_step(mode) * (iter_count(w, mode) - 1);
    endfunction

endpackage

// File: rtl/root_sum_unit_if.sv
// root_sum_unit_if
//   Request/response bundle of root_sum_unit.
//   Ports (master = requester, slave = the unit):
//     start  request pulse, accepted only while busy is low
//     mode   0 = cube root, 1 = square root (sampled with start)
//     a      scaled operand, W bits (sampled with start)
//     b      root operand, W bits (sampled with start)
//     res    result 3*a + root(b), W+2 bits
//     busy   operation in progress
//     done   one-cycle completion pulse
interface root_sum_unit_if #(
    parameter int W = 8
);
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W+1:0] res;
    logic         busy;
    logic         done;

    modport master (
        output start, mode, a, b,
        input  res, busy, done
    );

    modport slave (
        input  start, mode, a, b,
        output res, busy, done
    );
endinterface

// File: rtl/root_sum_unit_root_step.sv
// root_step
//   One digit-by-digit iteration of the integer cube/square root, purely combinational.
//   Ports:
//     x       remaining radicand (W bits)
//     y       partial root so far (ceil(W/2) bits)
//     s       shift of this iteration's trial
//     mode    0 = cube root, 1 = square root
//     x_next  radicand after conditionally subtracting the trial
//     y_next  partial root with the new digit appended
module root_step
    import root_sum_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]         x,
    input  logic [(W+1)/2-1:0]   y,
    input  logic [SHIFT_W-1:0]   s,
    input  logic                 mode,
    output logic [W-1:0]         x_next,
    output logic [(W+1)/2-1:0]   y_next
);
    localparam int YW = (W + 1) / 2;
    // The shifted trial can exceed x by far; evaluating it wide keeps the compare exact.
    localparam int TW = 2 * W + 2;

    logic [TW-1:0] y_dbl;
    logic [TW-1:0] t_cube;
    logic [TW-1:0] t_sqrt;
    logic [TW-1:0] trial;

    always_comb begin
        y_dbl  = TW'(y) << 1;
        // (y'+1)^3 - y'^3 = 3*y'*(y'+1) + 1
        t_cube = ((TW'(3) * y_dbl * (y_dbl + TW'(1))) + TW'(1)) << s;
        // (y'+1)^2 - y'^2 = 2*y' + 1
        t_sqrt = ((y_dbl << 1) + TW'(1)) << s;
        trial  = (mode == MODE_SQRT) ? t_sqrt : t_cube;

        if (TW'(x) >= trial) begin
            // trial <= x here, so its low W bits are the whole value.
            x_next = x - trial[W-1:0];
            y_next = YW'(y_dbl) | YW'(1);
        end else begin
            x_next = x;
            y_next = YW'(y_dbl);
        end
    end

endmodule

// File: rtl/root_sum_unit.sv
// root_sum_unit
//   Multi-cycle function unit computing res = 3*a + root(b), where root is the integer
//   cube root (mode 0) or integer square root (mode 1). Latency from the accepting
//   edge to done is ITER+1 cycles; a new start may be issued in the done cycle.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   root_sum_unit_if slave: start/mode/a/b in, res/busy/done out
module root_sum_unit
    import root_sum_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst,
    root_sum_unit_if.slave  bus
);
    localparam int YW = (W + 1) / 2;
    localparam int RW = W + 2;

    state_t               state, state_n;
    logic [W-1:0]         x, x_n, x_step;
    logic [YW-1:0]        y, y_n, y_step;
    logic [SHIFT_W-1:0]   s, s_n;
    logic [RW-1:0]        a3, a3_n;
    logic [RW-1:0]        res, res_n;
    logic                 mode_q, mode_n;
    logic                 busy, busy_n;
    logic                 done, done_n;

    root_step #(.W(W)) u_step (
        .x      (x),
        .y      (y),
        .s      (s),
        .mode   (mode_q),
        .x_next (x_step),
        .y_next (y_step)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_n = state;
        x_n     = x;
        y_n     = y;
        s_n     = s;
        a3_n    = a3;
        res_n   = res;
        mode_n  = mode_q;
        busy_n  = busy;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    x_n     = bus.b;
                    a3_n    = (RW'(bus.a) << 1) + RW'(bus.a);
                    y_n     = '0;
                    s_n     = SHIFT_W'(init_shift(W, bus.mode));
                    mode_n  = bus.mode;
                    busy_n  = 1'b1;
                    state_n = ROOT;
                end
            end
            ROOT: begin
                x_n = x_step;
                y_n = y_step;
                // The final iteration is the one that runs with shift 0.
                if (s == '0) begin
                    state_n = SUM;
                end else begin
                    s_n = s - SHIFT_W'(shift_step(mode_q));
                end
            end
            SUM: begin
                res_n   = a3 + RW'(y);
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            s      <= '0;
            a3     <= '0;
            res    <= '0;
            mode_q <= MODE_CBRT;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            x      <= x_n;
            y      <= y_n;
            s      <= s_n;
            a3     <= a3_n;
            res    <= res_n;
            mode_q <= mode_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    assign bus.res  = res;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule

// File: tb/tb_root_sum_unit.sv
// tb_root_sum_unit
//   Self-checking bench for root_sum_unit at W=8 (directed), W=5 (exhaustive) and
//   W=16 (random), against a plain-arithmetic reference model.
module tb_root_sum_unit;
    import root_sum_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    root_sum_unit_if #(.W(8))  if8  ();
    root_sum_unit_if #(.W(16)) if16 ();
    root_sum_unit_if #(.W(5))  if5  ();

    root_sum_unit #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    root_sum_unit #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    root_sum_unit #(.W(5))  dut5  (.clk(clk), .rst(rst), .bus(if5));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---- reference model ----
    function automatic longint ref_root(input logic m, input longint b);
        longint r = 0;
        if (m == MODE_SQRT) begin
            while ((r + 1) * (r + 1) <= b) r++;
        end else begin
            while ((r + 1) * (r + 1) * (r + 1) <= b) r++;
        end
        return r;
    endfunction

    function automatic longint ref_res(input logic m, input longint a, input longint b);
        return 3 * a + ref_root(m, b);
    endfunction

    function automatic int ref_lat(input int w, input logic m);
        int iters;
        iters = (m == MODE_SQRT) ? (w + 1) / 2 : (w + 2) / 3;
        return iters + 1;
    endfunction

    // ---- instance access (0: W=8, 1: W=16, 2: W=5) ----
    task automatic drive(input int inst, input logic st, input logic m,
                         input logic [31:0] a, input logic [31:0] b);
        case (inst)
            0: begin if8.start = st;  if8.mode = m;  if8.a = a[7:0];   if8.b = b[7:0];   end
            1: begin if16.start = st; if16.mode = m; if16.a = a[15:0]; if16.b = b[15:0]; end
            default: begin if5.start = st; if5.mode = m; if5.a = a[4:0]; if5.b = b[4:0]; end
        endcase
    endtask

    function automatic logic get_done(input int inst);
        case (inst)
            0:       return if8.done;
            1:       return if16.done;
            default: return if5.done;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            0:       return if8.busy;
            1:       return if16.busy;
            default: return if5.busy;
        endcase
    endfunction

    function automatic logic [33:0] get_res(input int inst);
        case (inst)
            0:       return 34'(if8.res);
            1:       return 34'(if16.res);
            default: return 34'(if5.res);
        endcase
    endfunction

    // Call at a negedge. Pulses start for one cycle, scrambles the inputs afterwards,
    // optionally re-pulses start at sample 'poke_at', and returns at the negedge where
    // done is seen. lat counts edges from the accepting edge to done.
    task automatic run_op(input int inst, input logic m, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at,
                          output logic [33:0] r, output int lat, output int busy_cyc);
        drive(inst, 1'b1, m, a, b);
        @(negedge clk);
        lat      = 0;
        busy_cyc = 0;
        while (get_done(inst) !== 1'b1 && lat < 60) begin
            if (get_busy(inst) === 1'b1) busy_cyc++;
            if (lat == poke_at) drive(inst, 1'b1, ~m, $urandom, $urandom);
            else                drive(inst, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
            @(negedge clk);
            lat++;
        end
        check("done_seen", 64'(get_done(inst)), 64'd1);
        check("busy_low_at_done", 64'(get_busy(inst)), 64'd0);
        r = get_res(inst);
    endtask

    typedef struct {
        logic    m;
        int      a;
        int      b;
        longint  exp;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        logic [33:0] r;
        logic [33:0] held;
        int          lat;
        int          bc;
        logic        saw_done;

        vecs[0] = '{MODE_CBRT, 5,   27,  18};
        vecs[1] = '{MODE_CBRT, 0,   255, 6};
        vecs[2] = '{MODE_CBRT, 0,   216, 6};
        vecs[3] = '{MODE_CBRT, 0,   215, 5};
        vecs[4] = '{MODE_SQRT, 255, 255, 780};
        vecs[5] = '{MODE_SQRT, 0,   0,   0};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, MODE_CBRT, 32'd0, 32'd0);
        #3;
        for (int i = 0; i < 3; i++) begin
            check("reset_res",  64'(get_res(i)),  64'd0);
            check("reset_busy", 64'(get_busy(i)), 64'd0);
            check("reset_done", 64'(get_done(i)), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed W=8 table.
        foreach (vecs[i]) begin
            run_op(0, vecs[i].m, 32'(vecs[i].a), 32'(vecs[i].b), -1, r, lat, bc);
            check("w8_res",  64'(r), 64'(vecs[i].exp));
            check("w8_lat",  64'(lat), 64'(ref_lat(8, vecs[i].m)));
            check("w8_busy_cycles", 64'(bc), 64'(ref_lat(8, vecs[i].m)));
        end
        @(negedge clk);
        check("done_one_cycle", 64'(get_done(0)), 64'd0);

        // Start pulsed mid-operation is ignored, then back-to-back start in the done cycle.
        @(negedge clk);
        run_op(0, MODE_CBRT, 32'd5, 32'd27, 1, r, lat, bc);
        check("ignore_start_res", 64'(r), 64'd18);
        check("ignore_start_lat", 64'(lat), 64'd4);
        run_op(0, MODE_SQRT, 32'd2, 32'd100, -1, r, lat, bc);
        check("b2b_res", 64'(r), 64'd16);
        check("b2b_lat", 64'(lat), 64'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_res_w8", 64'(get_res(0)), 64'd16);
        end

        // Asynchronous reset in the middle of ROOT.
        drive(0, 1'b1, MODE_CBRT, 32'd5, 32'd27);
        @(negedge clk);
        drive(0, 1'b0, MODE_CBRT, 32'd0, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(get_busy(0)), 64'd0);
        check("async_rst_done", 64'(get_done(0)), 64'd0);
        check("async_rst_res",  64'(get_res(0)),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (get_done(0) === 1'b1 || get_busy(0) === 1'b1) saw_done = 1'b1;
        end
        check("no_activity_after_rst", 64'(saw_done), 64'd0);
        run_op(0, MODE_CBRT, 32'd1, 32'd64, -1, r, lat, bc);
        check("post_rst_res", 64'(r), 64'd7);

        // W=5 exhaustive sweep.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 32; a++) begin
                for (int b = 0; b < 32; b++) begin
                    run_op(2, 1'(m), 32'(a), 32'(b), -1, r, lat, bc);
                    check("w5_res", 64'(r), 64'(ref_res(1'(m), a, b)));
                    check("w5_lat", 64'(lat), 64'(ref_lat(5, 1'(m))));
                    if ((a + b) % 7 == 0) begin
                        held = r;
                        repeat (2) @(negedge clk);
                        check("w5_hold", 64'(get_res(2)), 64'(held));
                    end
                end
            end
        end

        // W=16 randomized sweep, extremes first.
        for (int i = 0; i < 300; i++) begin
            logic        m;
            logic [15:0] a;
            logic [15:0] b;
            m = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            if (i < 4) begin
                m = 1'(i);
                a = (i < 2) ? 16'hFFFF : 16'h0000;
                b = (i < 2) ? 16'hFFFF : 16'h0000;
            end
            run_op(1, m, 32'(a), 32'(b), -1, r, lat, bc);
            check("w16_res", 64'(r), 64'(ref_res(m, longint'(a), longint'(b))));
            check("w16_lat", 64'(lat), 64'(ref_lat(16, m)));
            if (i % 5 == 0) begin
                held = r;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("w16_hold", 64'(get_res(1)), 64'(held));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/root_sum_unit.md
# root_sum_unit

Parametrised iterative arithmetic unit that computes `res = 3*a + root(b)`, where `root` is the integer cube root or integer square root, chosen per operation. It is the generalised successor of the fixed 8-bit cube-root function unit. It adds:
- a configurable operand width;
- a runtime root mode;
- a clean start/busy/done handshake;
- deterministic latency.

It sits beside the core as a multi-cycle function unit driven by a simple start pulse.

## Interface
- `W`, default 8: width of operands `a` and `b`. Legal range is 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse. Accepted only when `busy`=0.
- `mode`  in  1  0 = cube root, 1 = square root. Sampled with `start`.
- `a`  in  W  scaled operand. Sampled with `start`.
- `b`  in  W  root operand. Sampled with `start`.
- `res`  out  W+2  result. Reset value 0.
- `busy`  out  1  operation in progress. Reset value 0.
- `done`  out  1  one-cycle completion pulse. Reset value 0.

## Operation
- Iteration counts:
  - ITER_C = ceil(W/3) for cube root.
  - ITER_S = ceil(W/2) for square root.
  - ITER is the count for the sampled mode.
- States: IDLE, ROOT, SUM.
- **IDLE, `start`=1:**
  - Latch X=b and A3=3*a, computed as (a<<1)+a in W+2 bits.
  - Clear Y=0.
  - Set S=3*(ITER_C-1) for cube or 2*(ITER_S-1) for square.
  - Latch mode, set `busy`=1, go to ROOT.
- **ROOT, one iteration per cycle:**
  - Y' = 2Y.
  - Trial T: cube T = (3·Y'·(Y'+1)+1) << S; square T = (2·Y'+1) << S.
  - If X ≥ T: X -= T and Y = Y'+1. Otherwise Y = Y'.
  - S -= 3 (cube) or 2 (square).
  - After ITER iterations, go to SUM.
- **SUM:**
  - `res` = A3 + Y in W+2 bits. This cannot overflow, since 3(2^W−1)+2^ceil(W/2) < 2^(W+2).
  - Pulse `done`=1, set `busy`=0, go to IDLE.
- Width rules:
  - T and the X ≥ T compare are evaluated in 2W+2 bits. A shifted trial exceeding X must compare correctly, with no truncation.
  - Y is ceil(W/2) bits wide.
- `start` while `busy`=1 is ignored. It is not queued and has no effect on the running operation.
- `res` holds its value until the next SUM. It is not cleared on a new start.
- Reset at any time: immediately state=IDLE, `busy`=0, `done`=0, `res`=0. Internal X, Y, S, A3 are cleared.
- Inputs `a`, `b`, `mode` may change freely after acceptance.

## Timing
- Edge E0: `start`=1 with `busy`=0. `busy` is high from E0.
- Edges E1..E_ITER: root iterations.
- Edge E_(ITER+1): `res` valid, `done`=1 for exactly one cycle, `busy`=0.
- Latency from the accepting edge to `done` is ITER+1 cycles. For W=8: cube 4 cycles, square 5 cycles.
- Back-to-back operation: `start` may be asserted in the cycle where `done`=1. It is accepted at the next edge, so the throughput gap is zero.
- `done` and `busy` are never 1 together.

## Structure
- A shared package holds:
  - the mode encoding constants MODE_CBRT=0 and MODE_SQRT=1;
  - the state enum {IDLE, ROOT, SUM};
  - helper functions for ITER and initial S, given W and mode.
- One sub-module, `root_step`. It is purely combinational and parametrised by W.
  - Inputs: X, Y, S, mode.
  - Outputs: next X and next Y.
  - The top level holds only the FSM, the registers and the A3/SUM adder.

## Test plan
- W=8, cube, a=5, b=27 -> `res`=18, `done` 4 cycles after acceptance, `busy` high for exactly 4 cycles.
- W=8, cube, a=0, b=255 -> `res`=6. Also b=216 -> 6 and b=215 -> 5, checking the boundary of 6^3.
- W=8, square, a=255, b=255 -> `res`=780, `done` after 5 cycles. Also a=0, b=0 -> `res`=0.
- W=8, `start` pulsed again mid-operation with different a/b -> ignored, first result unchanged. Then `start` in the `done` cycle -> second result 4–5 cycles later.
- Assert `rst` during ROOT -> `busy`, `done`, `res` become 0 asynchronously, with no `done` pulse afterwards. A new start after release gives the correct result.
- W=16 and W=5: exhaustive or randomized sweep of a, b and mode against a golden model. Check `res`, the latency ITER+1, and that `res` is held stable between operations.
